hdr_window_3x3: RTL and testbench

Raster-to-window stage directly upstream of the HDR enhancement top. Accepts one RGB pixel per valid cycle in raster order and builds 3x3 neighbourhoods per channel using two line buffers and a 3x3 shift window. Emits one 27-tap window (R/G/B x 9) per interior centre pixel, which feeds the LIT/classification/NN datapath.

---
 rtl/hdr_window_3x3.sv | 145 ++++++++++++++
 tb/tb_hdr_window_3x3.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_window_3x3.sv
// Raster-to-window stage: builds a 3x3 neighbourhood per colour channel from
// a raster pixel stream and emits one 27-tap window per interior centre pixel.
module hdr_window_3x3 #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CRD_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid_i,
  input  logic               pix_sof_i,
  input  logic [PIX_W-1:0]   pix_r_i,
  input  logic [PIX_W-1:0]   pix_g_i,
  input  logic [PIX_W-1:0]   pix_b_i,
  output logic               win_valid_o,
  output logic [9*PIX_W-1:0] win_r_o,
  output logic [9*PIX_W-1:0] win_g_o,
  output logic [9*PIX_W-1:0] win_b_o,
  output logic [CRD_W-1:0]   win_x_o,
  output logic [CRD_W-1:0]   win_y_o,
  output logic               frame_done_o,
  output logic               sof_err_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CRD_W-1:0] X_LAST = CRD_W'(IMG_W - 1);
  localparam logic [CRD_W-1:0] Y_LAST = CRD_W'(IMG_H - 1);
  localparam logic [CRD_W-1:0] TWO    = CRD_W'(2);
  localparam logic [CRD_W-1:0] ONE    = CRD_W'(1);

  state_t state, state_nxt;
  logic [CRD_W-1:0] x_cnt, y_cnt, cx, cy;
  logic accept, last_pix, emit, frame_err;
  logic [AW-1:0] lb_idx;
  logic [3*PIX_W-1:0] pix, lb0_rd, lb1_rd;
  logic [3*PIX_W-1:0] lb0 [IMG_W];
  logic [3*PIX_W-1:0] lb1 [IMG_W];
  logic [3*PIX_W-1:0] win [9];
  logic [3*PIX_W-1:0] win_nxt [9];
  logic [9*PIX_W-1:0] r_pack, g_pack, b_pack;

  // A sof pixel always restarts at (0,0), even in the middle of a frame.
  always_comb begin
    accept    = pix_valid_i & ((state == ACTIVE) | pix_sof_i);
    frame_err = pix_valid_i & ((state == IDLE) ? ~pix_sof_i : pix_sof_i);
    cx        = pix_sof_i ? '0 : x_cnt;
    cy        = pix_sof_i ? '0 : y_cnt;
    last_pix  = (cx == X_LAST) & (cy == Y_LAST);
    emit      = accept & (cx >= TWO) & (cy >= TWO);
    lb_idx    = cx[AW-1:0];
    pix       = {pix_r_i, pix_g_i, pix_b_i};
    lb0_rd    = lb0[lb_idx];
    lb1_rd    = lb1[lb_idx];
  end

  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = last_pix ? IDLE : ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (last_pix) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (cx == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= cy + ONE;
      end else begin
        x_cnt <= cx + ONE;
        y_cnt <= cy;
      end
    end
  end

  // Window shifts left; the new right column is {row y-2, row y-1, row y}.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[3*r]   = win[3*r+1];
      win_nxt[3*r+1] = win[3*r+2];
    end
    win_nxt[2] = lb0_rd;
    win_nxt[5] = lb1_rd;
    win_nxt[8] = pix;
  end

  always_comb begin
    r_pack = '0;
    g_pack = '0;
    b_pack = '0;
    for (int n = 0; n < 9; n++) begin
      r_pack[n*PIX_W +: PIX_W] = win_nxt[n][3*PIX_W-1 -: PIX_W];
      g_pack[n*PIX_W +: PIX_W] = win_nxt[n][2*PIX_W-1 -: PIX_W];
      b_pack[n*PIX_W +: PIX_W] = win_nxt[n][PIX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[lb_idx] <= lb1_rd;
      lb1[lb_idx] <= pix;
      for (int n = 0; n < 9; n++)
        win[n] <= win_nxt[n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      win_valid_o  <= 1'b0;
      win_r_o      <= '0;
      win_g_o      <= '0;
      win_b_o      <= '0;
      win_x_o      <= '0;
      win_y_o      <= '0;
      frame_done_o <= 1'b0;
      sof_err_o    <= 1'b0;
    end else begin
      win_valid_o  <= emit;
      frame_done_o <= emit & last_pix;
      sof_err_o    <= frame_err;
      if (emit) begin
        win_r_o <= r_pack;
        win_g_o <= g_pack;
        win_b_o <= b_pack;
        win_x_o <= cx - ONE;
        win_y_o <= cy - ONE;
      end
    end
  end

endmodule

// File: tb/tb_hdr_window_3x3.sv
// Scoreboard bench for hdr_window_3x3 on an 8x6 frame with R=16*y+x, G=~R, B=x.
module tb_hdr_window_3x3;

  localparam int W = 8;
  localparam int H = 6;

  typedef struct packed {
    logic [71:0] r;
    logic [71:0] g;
    logic [71:0] b;
    logic [15:0] x;
    logic [15:0] y;
    logic        fd;
  } win_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pix_valid_i = 1'b0;
  logic        pix_sof_i = 1'b0;
  logic [7:0]  pix_r_i = '0;
  logic [7:0]  pix_g_i = '0;
  logic [7:0]  pix_b_i = '0;
  logic        win_valid_o;
  logic [71:0] win_r_o, win_g_o, win_b_o;
  logic [15:0] win_x_o, win_y_o;
  logic        frame_done_o, sof_err_o;

  win_t exp_q[$];
  win_t last_exp;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   win_cnt = 0;
  int   fd_cnt = 0;
  int   err_cnt = 0;
  bit   hold_en = 1'b0;

  hdr_window_3x3 #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .CRD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid_i(pix_valid_i), .pix_sof_i(pix_sof_i),
    .pix_r_i(pix_r_i), .pix_g_i(pix_g_i), .pix_b_i(pix_b_i),
    .win_valid_o(win_valid_o), .win_r_o(win_r_o), .win_g_o(win_g_o), .win_b_o(win_b_o),
    .win_x_o(win_x_o), .win_y_o(win_y_o), .frame_done_o(frame_done_o), .sof_err_o(sof_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] r_at(input int x, input int y);
    return 8'(16 * y + x);
  endfunction

  // Expected window produced by accepting pixel (x,y), built from coordinates.
  function automatic win_t model_win(input int x, input int y);
    win_t w;
    int px, py;
    w = '0;
    for (int n = 0; n < 9; n++) begin
      px = x - 1 + (n % 3) - 1;
      py = y - 1 + (n / 3) - 1;
      w.r[n*8 +: 8] = r_at(px, py);
      w.g[n*8 +: 8] = ~r_at(px, py);
      w.b[n*8 +: 8] = 8'(px);
    end
    w.x  = 16'(x - 1);
    w.y  = 16'(y - 1);
    w.fd = (x == W - 1) && (y == H - 1);
    return w;
  endfunction

  // One clock of stimulus; the scoreboard is popped when a window appears.
  task automatic send(input logic v, input logic s, input int x, input int y);
    win_t e;
    pix_valid_i = v;
    pix_sof_i   = s;
    pix_r_i     = v ? r_at(x, y) : 8'h00;
    pix_g_i     = v ? ~r_at(x, y) : 8'h00;
    pix_b_i     = v ? 8'(x) : 8'h00;
    if (v && x >= 2 && y >= 2)
      exp_q.push_back(model_win(x, y));
    @(negedge clk);
    if (sof_err_o === 1'b1) err_cnt++;
    if (win_valid_o === 1'b1) begin
      win_cnt++;
      if (frame_done_o === 1'b1) fd_cnt++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_window: got x=%0d y=%0d, required no window", win_x_o, win_y_o);
      end else begin
        e = exp_q.pop_front();
        if ({win_r_o, win_g_o, win_b_o, win_x_o, win_y_o, frame_done_o} !== {e.r, e.g, e.b, e.x, e.y, e.fd}) begin
          tests_failed++;
          $display("[TB] FAIL window: got r=%h g=%h b=%h x=%0d y=%0d fd=%b, required r=%h g=%h b=%h x=%0d y=%0d fd=%b",
                   win_r_o, win_g_o, win_b_o, win_x_o, win_y_o, frame_done_o, e.r, e.g, e.b, e.x, e.y, e.fd);
        end
        last_exp = e;
      end
    end else if (hold_en) begin
      tests_run++;
      if ({win_r_o, win_g_o, win_b_o, win_x_o, win_y_o, frame_done_o} !== {last_exp.r, last_exp.g, last_exp.b, last_exp.x, last_exp.y, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL hold: got r=%h x=%0d y=%0d fd=%b, required r=%h x=%0d y=%0d fd=0",
                 win_r_o, win_x_o, win_y_o, frame_done_o, last_exp.r, last_exp.x, last_exp.y);
      end
    end
  endtask

  task automatic send_frame(input int npix, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) send(1'b0, 1'b0, 0, 0);
      send(1'b1, i == 0, i % W, i / W);
    end
  endtask

  task automatic clear_counts();
    win_cnt = 0;
    fd_cnt  = 0;
    err_cnt = 0;
  endtask

  task automatic check_counts(input string name, input int wins, input int fds, input int errs);
    tests_run++;
    if (win_cnt != wins || fd_cnt != fds || err_cnt != errs || exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_counts: got windows=%0d frame_done=%0d sof_err=%0d pending=%0d, required %0d %0d %0d 0",
               name, win_cnt, fd_cnt, err_cnt, exp_q.size(), wins, fds, errs);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    pix_valid_i = 1'b1;
    pix_sof_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if ({win_valid_o, win_r_o, win_g_o, win_b_o, win_x_o, win_y_o, frame_done_o, sof_err_o} !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs: got valid=%b r=%h x=%0d y=%0d fd=%b err=%b, required all 0",
                 win_valid_o, win_r_o, win_x_o, win_y_o, frame_done_o, sof_err_o);
      end
    end
    rst_n = 1'b0;
    last_exp = '0;
    clear_counts();
    send(1'b1, 1'b0, 0, 0);
    tests_run++;
    if (sof_err_o !== 1'b1 || win_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sof_err_idle: got err=%b valid=%b, required err=1 valid=0", sof_err_o, win_valid_o);
    end
    send(1'b0, 1'b0, 0, 0);
    tests_run++;
    if (sof_err_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sof_err_pulse: got %b, required 0", sof_err_o);
    end
    check_counts("reset", 0, 0, 1);
  endtask

  task automatic test_single_frame();
    clear_counts();
    for (int i = 0; i < W * H; i++) begin
      send(1'b1, i == 0, i % W, i / W);
      if (i == 17) begin
        tests_run++;
        if (win_valid_o !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL early_window: got valid=%b, required 0", win_valid_o);
        end
      end
      if (i == 18) begin
        tests_run++;
        if (win_valid_o !== 1'b1 || win_r_o !== 72'h22_21_20_12_11_10_02_01_00 ||
            win_g_o !== ~72'h22_21_20_12_11_10_02_01_00 || win_x_o !== 16'd1 || win_y_o !== 16'd1) begin
          tests_failed++;
          $display("[TB] FAIL first_window: got valid=%b r=%h g=%h x=%0d y=%0d, required 1 222120121110020100 inverse 1 1",
                   win_valid_o, win_r_o, win_g_o, win_x_o, win_y_o);
        end
      end
      if (i == W * H - 1) begin
        tests_run++;
        if (win_r_o[39:32] !== 8'h46 || frame_done_o !== 1'b1 || win_x_o !== 16'd6 || win_y_o !== 16'd4) begin
          tests_failed++;
          $display("[TB] FAIL last_window: got r5=%h fd=%b x=%0d y=%0d, required 46 1 6 4",
                   win_r_o[39:32], frame_done_o, win_x_o, win_y_o);
        end
      end
    end
    send(1'b0, 1'b0, 0, 0);
    check_counts("single_frame", 24, 1, 0);
  endtask

  task automatic test_gaps();
    clear_counts();
    hold_en = 1'b1;
    send_frame(W * H, 1'b1);
    send(1'b0, 1'b0, 0, 0);
    send(1'b0, 1'b0, 0, 0);
    hold_en = 1'b0;
    check_counts("gaps", 24, 1, 0);
  endtask

  task automatic test_sof_restart();
    int old_wins;
    clear_counts();
    send_frame(30, 1'b0);
    old_wins = win_cnt;
    send(1'b1, 1'b1, 0, 0);
    tests_run++;
    if (sof_err_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sof_err_restart: got %b, required 1", sof_err_o);
    end
    for (int i = 1; i < W * H; i++)
      send(1'b1, 1'b0, i % W, i / W);
    send(1'b0, 1'b0, 0, 0);
    tests_run++;
    if (old_wins != 10) begin
      tests_failed++;
      $display("[TB] FAIL aborted_frame_windows: got %0d, required 10", old_wins);
    end
    check_counts("sof_restart", 34, 1, 1);
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_frame(W * H, 1'b0);
    send_frame(W * H, 1'b0);
    send(1'b0, 1'b0, 0, 0);
    check_counts("back_to_back", 48, 2, 0);
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    send_frame(25, 1'b0);
    rst_n = 1'b1;
    pix_valid_i = 1'b0;
    pix_sof_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({win_valid_o, win_r_o, win_x_o, win_y_o, frame_done_o, sof_err_o} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_frame: got valid=%b r=%h x=%0d y=%0d fd=%b err=%b, required all 0",
               win_valid_o, win_r_o, win_x_o, win_y_o, frame_done_o, sof_err_o);
    end
    rst_n = 1'b0;
    last_exp = '0;
    check_counts("partial_frame", 6, 0, 0);
    clear_counts();
    send_frame(W * H, 1'b0);
    send(1'b0, 1'b0, 0, 0);
    check_counts("fresh_frame", 24, 1, 0);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gaps();
    test_sof_restart();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
